instr_issue_queue: RTL and testbench
====================================

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of 2, 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  producer offers in_instr this cycle.
REQ-005 SHALL have port in_instr  input  16  instruction word to enqueue.
REQ-006 SHALL have port in_ready  output  1  queue can accept (= !full).
REQ-007 SHALL have port flush  input  1  discard all queued, not-yet-issued entries.
REQ-008 SHALL have port waiting  input  1  CPU idle indication from downstream cpu.
REQ-009 SHALL have port load  output  1  drives cpu load.
REQ-010 SHALL have port start  output  1  drives cpu start.
REQ-011 SHALL have port instr  output  16  drives cpu instr; registered.
REQ-012 SHALL have port busy  output  1  queue non-empty or FSM not IDLE.
REQ-013 SHALL have port issued_cnt  output  16  count of instructions issued.
REQ-014 SHALL have port hang  output  1  sticky CPU-timeout flag (see Configuration).

Function
REQ-015 SHALL accept a push on any edge where in_valid && in_ready && !flush; no bypass path.
REQ-016 SHALL drive in_ready low exactly when DEPTH entries are held; pointers wrap modulo DEPTH.
REQ-017 SHALL implement FSM states IDLE, ISSUE, ACK, RUN.
REQ-018 IDLE -> ISSUE when queue non-empty and waiting==1; else stay IDLE.
REQ-019 ISSUE SHALL last exactly one cycle: load=1, start=1, instr=head entry; head popped at exiting edge; -> ACK.
REQ-020 ACK -> RUN on first cycle waiting==0; RUN -> IDLE on first cycle waiting==1.
REQ-021 load and start SHALL be 0 in every state other than ISSUE.
REQ-022 instr SHALL hold the last issued word through ACK, RUN and IDLE until the next ISSUE.
REQ-023 Latency: push at edge E0 into empty queue with FSM IDLE and waiting=1 -> ISSUE after E1, start high between E1 and E2.
REQ-024 issued_cnt SHALL increment by 1 at each ISSUE exit, wrapping 0xFFFF -> 0x0000.
REQ-025 flush SHALL empty the queue at that edge; flush wins over a same-cycle push (push dropped); an in-flight ACK/RUN instruction completes normally.
REQ-026 A pop and push on the same edge SHALL both take effect; occupancy unchanged.

Reset
REQ-027 rst SHALL, at the next rising edge, set FSM IDLE, queue empty, load=0, start=0, instr=0, issued_cnt=0, hang=0, in_ready=1, busy=0.
REQ-028 rst mid-operation (any state) SHALL abandon the in-flight instruction with no further load/start pulse; rst dominates push, flush and timeout.

Configuration
REQ-029 Macro ISSUE_TIMEOUT_EN defined: 8-bit watchdog counts cycles spent in ACK+RUN, cleared on ISSUE; on reaching 255 SHALL set hang=1 (sticky until rst) and force FSM to IDLE.
REQ-030 Macro ISSUE_TIMEOUT_EN undefined: no watchdog logic; hang tied to 0; ACK/RUN wait indefinitely.

Verification
REQ-031 Reset, then push 0xD001 with waiting=1 -> start/load high for one cycle two edges later, instr=0xD001, issued_cnt=1.
REQ-032 Push 9 words with waiting held 0 (DEPTH=8) -> in_ready low after 8th, 9th not accepted, busy=1, no start pulse.
REQ-033 Queue 3 words, model cpu dropping waiting 1 cycle after start and raising 4 cycles later -> 3 single-cycle start pulses in push order, issued_cnt=3, busy=0 at end.
REQ-034 Queue 4 words, assert flush during first instruction's RUN -> exactly one start pulse total, queue empty, issued_cnt=1.
REQ-035 ISSUE_TIMEOUT_EN defined, waiting stuck 0 after issue -> hang=1 255 cycles after ISSUE exit, FSM IDLE; undefined -> hang stays 0.
REQ-036 Assert rst while in RUN with 2 queued -> all outputs at reset values next cycle, no further start pulses.

Source files
------------

// File: rtl/instr_issue_queue.sv
// Instruction FIFO feeding a downstream cpu via a load/start/waiting handshake.
// Optional watchdog on ACK+RUN enabled by defining ISSUE_TIMEOUT_EN.
module instr_issue_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  input  logic        waiting,
  output logic        load,
  output logic        start,
  output logic [15:0] instr,
  output logic        busy,
  output logic [15:0] issued_cnt,
  output logic        hang
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StAck, StRun} state_e;

  logic [15:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     issued_q, issued_d;
  logic            full, empty, push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full && !flush;
  // The head is only popped when the queue survives this edge.
  assign pop   = (state_q == StIssue) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

`ifdef ISSUE_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       hang_q, hang_d;
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    issued_d = issued_q;
    unique case (state_q)
      StIdle: begin
        // A flushed head is discarded, never issued.
        if (!empty && waiting && !flush) begin
          state_d = StIssue;
          instr_d = mem_q[rd_ptr_q];
        end
      end
      StIssue: begin
        state_d  = StAck;
        issued_d = issued_q + 16'd1;
      end
      StAck:   if (!waiting) state_d = StRun;
      StRun:   if (waiting)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef ISSUE_TIMEOUT_EN
    hang_d = hang_q;
    wdog_d = '0;
    if (state_q == StAck || state_q == StRun) begin
      wdog_d = wdog_q + 8'd1;
      if (wdog_d == 8'hFF) begin
        hang_d  = 1'b1;
        state_d = StIdle;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      instr_q  <= '0;
      issued_q <= '0;
`ifdef ISSUE_TIMEOUT_EN
      wdog_q   <= '0;
      hang_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      instr_q  <= instr_d;
      issued_q <= issued_d;
`ifdef ISSUE_TIMEOUT_EN
      wdog_q   <= wdog_d;
      hang_q   <= hang_d;
`endif
    end
  end

  assign in_ready   = !full;
  assign load       = (state_q == StIssue);
  assign start      = (state_q == StIssue);
  assign instr      = instr_q;
  assign busy       = !empty || (state_q != StIdle);
  assign issued_cnt = issued_q;
`ifdef ISSUE_TIMEOUT_EN
  assign hang       = hang_q;
`else
  assign hang       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_instr_issue_queue;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        waiting = 1'b0;
  logic        in_ready, load, start, busy, hang;
  logic [15:0] instr, issued_cnt;
  logic [36:0] dut_vec;

  instr_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .waiting    (waiting),
    .load       (load),
    .start      (start),
    .instr      (instr),
    .busy       (busy),
    .issued_cnt (issued_cnt),
    .hang       (hang)
  );

  always #5 clk = ~clk;

  assign dut_vec = {in_ready, load, start, instr, busy, issued_cnt, hang};

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic [15:0] issued_words[$];

  // Reference model: phase 0 idle, 1 issuing, 2 awaiting ack, 3 cpu running.
  logic [15:0] mq[$];
  int          m_ph   = 0;
  logic [15:0] m_last = '0;
  logic [15:0] m_cnt  = '0;
  logic        m_hang = 1'b0;
  int          m_wd   = 0;

  function automatic logic [36:0] model_vec();
    logic busy_e;
    busy_e = (mq.size() != 0) || (m_ph != 0);
    return {(mq.size() < DEPTH), (m_ph == 1), (m_ph == 1), m_last, busy_e, m_cnt, m_hang};
  endfunction

  task automatic tick();
    logic r, v, f, w, was_full;
    logic [15:0] d;
    int nph;
    r = rst; v = in_valid; f = flush; w = waiting; d = in_instr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ph = 0; m_last = '0; m_cnt = '0; m_hang = 1'b0; m_wd = 0;
    end else begin
      nph = m_ph;
      was_full = (mq.size() >= DEPTH);
      case (m_ph)
        0: if (mq.size() > 0 && w && !f) begin nph = 1; m_last = mq[0]; end
        1: begin nph = 2; m_cnt = m_cnt + 16'd1; end
        2: if (!w) nph = 3;
        default: if (w) nph = 0;
      endcase
`ifdef ISSUE_TIMEOUT_EN
      if (m_ph >= 2) begin
        m_wd++;
        if (m_wd == 255) begin m_hang = 1'b1; nph = 0; end
      end else m_wd = 0;
`endif
      if (f) mq.delete();
      else begin
        if (m_ph == 1) void'(mq.pop_front());
        if (v && !was_full) mq.push_back(d);
      end
      m_ph = nph;
    end
    #1;
    if (start === 1'b1) begin
      pulses++;
      issued_words.push_back(instr);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
    pulses = 0;
    issued_words.delete();
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1; in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    waiting = 1'b1;
    apply_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", load); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
    n_checks++; if (instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr); end
    n_checks++; if (issued_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", issued_cnt); end
    n_checks++; if (hang !== 1'b0) begin n_fail++; $display("FAIL reset_hang got %b want 0", hang); end
  endtask

  task automatic test_basic_issue();
    apply_reset();
    waiting = 1'b1;
    push_word(16'hD001);
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL basic_e0_start got %b want 0", start); end
    tick();
    n_checks++; if ({load, start} !== 2'b11) begin n_fail++; $display("FAIL basic_pulse got %b want 11", {load, start}); end
    n_checks++; if (instr !== 16'hD001) begin n_fail++; $display("FAIL basic_instr got %h want d001", instr); end
    tick();
    n_checks++; if ({load, start} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse_end got %b want 00", {load, start}); end
    n_checks++; if (issued_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt got %0d want 1", issued_cnt); end
    n_checks++; if (instr !== 16'hD001) begin n_fail++; $display("FAIL basic_instr_hold got %h want d001", instr); end
    waiting = 1'b0; tick();
    waiting = 1'b1; tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_full();
    apply_reset();
    waiting = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (in_ready !== (i < DEPTH)) begin
        n_fail++; $display("FAIL full_ready_%0d got %b want %b", i, in_ready, (i < DEPTH));
      end
      push_word(16'hA000 + 16'(i));
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_end got %b want 0", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b want 1", busy); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL full_no_start got %0d pulses want 0", pulses); end
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++; if ({in_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL full_flush got %b want 10", {in_ready, busy}); end
  endtask

  task automatic test_cpu_handshake();
    logic [15:0] w[3];
    int cyc = 0, down_at = -1, up_at = -1;
    logic prev = 1'b0;
    apply_reset();
    waiting = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom);
      push_word(w[i]);
    end
    waiting = 1'b1;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (start === 1'b1) begin
        n_checks++;
        if (prev) begin n_fail++; $display("FAIL hs_pulse_width got 2+ cycles want 1"); end
        down_at = cyc + 1; up_at = cyc + 5;
      end
      prev = start;
      if (cyc == down_at) waiting = 1'b0;
      if (cyc == up_at) waiting = 1'b1;
      if (pulses == 3 && busy === 1'b0) break;
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL hs_pulses got %0d want 3", pulses); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= issued_words.size() || issued_words[i] !== w[i]) begin
        n_fail++;
        $display("FAIL hs_order_%0d got %h want %h", i,
                 (i < issued_words.size()) ? issued_words[i] : 16'hxxxx, w[i]);
      end
    end
    n_checks++; if (issued_cnt !== 16'd3) begin n_fail++; $display("FAIL hs_cnt got %0d want 3", issued_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy got %b want 0", busy); end
  endtask

  // Reach RUN for the first queued word; returns 0 if no start pulse appears.
  task automatic run_first(output bit ok);
    int n = 0;
    ok = 1'b0;
    waiting = 1'b1;
    while (n < 20 && start !== 1'b1) begin tick(); n++; end
    ok = (start === 1'b1);
    waiting = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_flush();
    bit ok;
    apply_reset();
    waiting = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'hB000 + 16'(i));
    run_first(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_first_start got none want 1 pulse"); end
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL flush_in_run got ready=%b busy=%b want 1 1", in_ready, busy); end
    waiting = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL flush_pulses got %0d want 1", pulses); end
    n_checks++; if (issued_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt got %0d want 1", issued_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    waiting = 1'b1;
    push_word(16'hC0DE);
    while (n < 20 && start !== 1'b1) begin tick(); n++; end
    waiting = 1'b0;
    tick();
    for (int i = 0; i < 254; i++) tick();
    n_checks++; if (hang !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_before got hang=%b busy=%b want 0 1", hang, busy); end
    tick();
`ifdef ISSUE_TIMEOUT_EN
    n_checks++; if (hang !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_fire got hang=%b busy=%b want 1 0", hang, busy); end
`else
    n_checks++; if (hang !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_none got hang=%b busy=%b want 0 1", hang, busy); end
`endif
    for (int i = 0; i < 20; i++) tick();
`ifdef ISSUE_TIMEOUT_EN
    n_checks++; if (hang !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", hang); end
`else
    n_checks++; if (hang !== 1'b0) begin n_fail++; $display("FAIL to_stays0 got %b want 0", hang); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    waiting = 1'b0;
    for (int i = 0; i < 3; i++) push_word(16'hE000 + 16'(i));
    run_first(ok);
    n_checks++; if (!ok || busy !== 1'b1) begin n_fail++; $display("FAIL rm_setup got ok=%b busy=%b want 1 1", ok, busy); end
    rst = 1'b1; in_valid = 1'b1; in_instr = 16'hFFFF; flush = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0}) begin
      n_fail++; $display("FAIL rm_outputs got %h want %h", dut_vec, {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0});
    end
    pulses = 0;
    waiting = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (pulses != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_quiet got pulses=%0d busy=%b want 0 0", pulses, busy); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_instr = 16'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) waiting = ~waiting;
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random_c%0d got %h want %h", c, dut_vec, model_vec());
      end
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_full();
    test_cpu_handshake();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
